// File: rtl/ni_flit_tx.sv
// ni_flit_tx: clocked valid/ready stream to four-phase QDI flit transmitter.
// Each accepted beat becomes one registered codeword: four 1-of-4 data digits,
// a 1-of-3 type (head/body/tail) and a one-hot VC. The codeword is held until the
// synchronised ack rises, then the rails return to spacer and the block waits
// for the ack to fall before the next beat is accepted.
module ni_flit_tx #(
   parameter int VCN  = 2,
   parameter int SYNC = 2,
   parameter int CW   = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           s_valid,
   output logic           s_ready,
   input  logic [7:0]     s_data,
   input  logic           s_last,
   input  logic [VCN-1:0] s_vc,
   output logic [3:0]     do0,
   output logic [3:0]     do1,
   output logic [3:0]     do2,
   output logic [3:0]     do3,
   output logic [2:0]     dot,
   output logic [VCN-1:0] dovc,
   input  logic           doa,
   output logic           busy,
   output logic [CW-1:0]  flit_cnt
);

   // A one-stage synchroniser is never safe for an asynchronous ack.
   localparam int SYNC_N = (SYNC < 2) ? 2 : SYNC;

   localparam logic [2:0] TYPE_HEAD = 3'b001;
   localparam logic [2:0] TYPE_BODY = 3'b010;
   localparam logic [2:0] TYPE_TAIL = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_RTZ  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [SYNC_N-1:0]   sync_q;
   logic [SYNC_N-1:0]   fill_q;
   logic                in_frame_q, in_frame_d;
   logic [VCN-1:0]      vc_q, vc_d;
   logic [3:0]          do0_q, do0_d;
   logic [3:0]          do1_q, do1_d;
   logic [3:0]          do2_q, do2_d;
   logic [3:0]          do3_q, do3_d;
   logic [2:0]          dot_q, dot_d;
   logic [VCN-1:0]      dovc_q, dovc_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   logic                ack_s;
   logic                sync_ok;
   logic                ready_c;
   logic [3:0]          enc0, enc1, enc2, enc3;
   logic [VCN-1:0]      vc_low;
   logic [VCN-1:0]      vc_pick;
   logic                is_head;
   logic [2:0]          type_sel;
   logic [VCN-1:0]      vc_sel;

   // Ack synchroniser plus a fill marker: until the chain has been loaded with
   // real samples of doa after reset, its output cannot be trusted as "ack low".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         fill_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_N-2:0], doa};
         fill_q <= {fill_q[SYNC_N-2:0], 1'b1};
      end
   end

   assign ack_s   = sync_q[SYNC_N-1];
   assign sync_ok = fill_q[SYNC_N-1];

   // Digit i carries s_data[2i+1:2i]; exactly one of its four rails is raised.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         logic [1:0] dig;
         assign dig      = s_data[2*gi+1:2*gi];
         assign enc0[gi] = (dig == 2'd0);
         assign enc1[gi] = (dig == 2'd1);
         assign enc2[gi] = (dig == 2'd2);
         assign enc3[gi] = (dig == 2'd3);
      end
   endgenerate

   // Lowest set bit of s_vc wins; an empty s_vc falls back to VC0.
   assign vc_low  = s_vc & (~s_vc + VCN'(1));
   assign vc_pick = (s_vc == '0) ? VCN'(1) : vc_low;

   // The first beat of a frame is always a head, whatever s_last says.
   assign is_head  = ~in_frame_q;
   assign type_sel = is_head ? TYPE_HEAD : (s_last ? TYPE_TAIL : TYPE_BODY);
   assign vc_sel   = is_head ? vc_pick : vc_q;

   // State and output registers; reset forces the rails to spacer immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         in_frame_q <= 1'b0;
         vc_q       <= '0;
         do0_q      <= '0;
         do1_q      <= '0;
         do2_q      <= '0;
         do3_q      <= '0;
         dot_q      <= '0;
         dovc_q     <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         in_frame_q <= in_frame_d;
         vc_q       <= vc_d;
         do0_q      <= do0_d;
         do1_q      <= do1_d;
         do2_q      <= do2_d;
         do3_q      <= do3_d;
         dot_q      <= dot_d;
         dovc_q     <= dovc_d;
         cnt_q      <= cnt_d;
      end
   end

   // Four-phase sequencing: load codeword, wait ack high, spacer, wait ack low.
   always_comb begin
      state_d    = state_q;
      in_frame_d = in_frame_q;
      vc_d       = vc_q;
      do0_d      = do0_q;
      do1_d      = do1_q;
      do2_d      = do2_q;
      do3_d      = do3_q;
      dot_d      = dot_q;
      dovc_d     = dovc_q;
      cnt_d      = cnt_q;
      ready_c    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            ready_c = ~ack_s & sync_ok;
            if (s_valid && ready_c) begin
               do0_d   = enc0;
               do1_d   = enc1;
               do2_d   = enc2;
               do3_d   = enc3;
               dot_d   = type_sel;
               dovc_d  = vc_sel;
               state_d = ST_SEND;
               if (is_head) begin
                  in_frame_d = 1'b1;
                  vc_d       = vc_pick;
               end else if (s_last) begin
                  in_frame_d = 1'b0;
               end
            end
         end
         ST_SEND: begin
            if (ack_s) begin
               do0_d   = '0;
               do1_d   = '0;
               do2_d   = '0;
               do3_d   = '0;
               dot_d   = '0;
               dovc_d  = '0;
               state_d = ST_RTZ;
            end
         end
         ST_RTZ: begin
            if (!ack_s) begin
               cnt_d   = cnt_q + CW'(1);
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign s_ready  = ready_c;
   assign do0      = do0_q;
   assign do1      = do1_q;
   assign do2      = do2_q;
   assign do3      = do3_q;
   assign dot      = dot_q;
   assign dovc     = dovc_q;
   assign busy     = in_frame_q | (state_q != ST_IDLE);
   assign flit_cnt = cnt_q;

endmodule

// File: tb/tb_ni_flit_tx.sv
// Directed bench for ni_flit_tx, built with CW=4 so the flit counter wraps.
// Expected rails are written out by hand as {do3,do2,do1,do0}.
module tb_ni_flit_tx;

   localparam int VCN  = 2;
   localparam int SYNC = 2;
   localparam int CW   = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           s_valid;
   logic           s_ready;
   logic [7:0]     s_data;
   logic           s_last;
   logic [VCN-1:0] s_vc;
   logic [3:0]     do0, do1, do2, do3;
   logic [2:0]     dot;
   logic [VCN-1:0] dovc;
   logic           doa;
   logic           busy;
   logic [CW-1:0]  flit_cnt;

   int             tests = 0;
   int             fails = 0;
   logic [CW-1:0]  exp_cnt = '0;

   ni_flit_tx #(.VCN(VCN), .SYNC(SYNC), .CW(CW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .s_last   (s_last),
      .s_vc     (s_vc),
      .do0      (do0),
      .do1      (do1),
      .do2      (do2),
      .do3      (do3),
      .dot      (dot),
      .dovc     (dovc),
      .doa      (doa),
      .busy     (busy),
      .flit_cnt (flit_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete flit: accept, check codeword, hold, ack, spacer, release.
   task automatic send_flit(input string tag, input logic [7:0] d, input logic last,
                            input logic [1:0] vc, input logic [15:0] erail,
                            input logic [2:0] et, input logic [1:0] ev,
                            input int hold, input logic junk);
      int   n;
      logic stable;
      n = 0;
      while (s_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_ready"}, 32'(s_ready), 32'd1);
      s_valid = 1'b1; s_data = d; s_last = last; s_vc = vc;
      @(posedge clk); #1;
      if (junk) begin
         s_data = ~d; s_last = ~last; s_vc = ~vc;
      end else begin
         s_valid = 1'b0;
      end
      chk({tag, "_rails"}, 32'({do3, do2, do1, do0}), 32'(erail));
      chk({tag, "_dot"}, 32'(dot), 32'(et));
      chk({tag, "_dovc"}, 32'(dovc), 32'(ev));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      stable = 1'b1;
      for (int c = 0; c < hold; c++) begin
         @(posedge clk); #1;
         if ({do3, do2, do1, do0, dot, dovc, s_ready} !== {erail, et, ev, 1'b0})
            stable = 1'b0;
      end
      chk({tag, "_stable"}, 32'(stable), 32'd1);
      s_valid = 1'b0;
      doa = 1'b1;
      n = 0;
      while (dot !== 3'b000 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_spacer"}, 32'({do3, do2, do1, do0, dot, dovc}), 32'd0);
      chk({tag, "_rtz_nrdy"}, 32'(s_ready), 32'd0);
      doa = 1'b0;
      exp_cnt = exp_cnt + 1'b1;
      n = 0;
      while (flit_cnt !== exp_cnt && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_cnt"}, 32'(flit_cnt), 32'(exp_cnt));
      $display("[TB] flit %s data=%02h type=%03b vc=%02b cnt=%0d", tag, d, et, ev, flit_cnt);
   endtask

   initial begin
      int   n;
      logic quiet;

      // Reset held with s_valid asserted
      rst_n = 1'b0; s_valid = 1'b1; s_data = 8'h00; s_last = 1'b0; s_vc = 2'b01; doa = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(s_ready), 32'd0);
      chk("rst_rails", 32'({do3, do2, do1, do0, dot, dovc}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1; s_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_cnt", 32'(flit_cnt), 32'd0);

      // Frame 1: head/body/tail on VC1, ack after 3 cycles
      send_flit("f1_head", 8'h35, 1'b0, 2'b10, 16'h4038, 3'b001, 2'b10, 3, 1'b0);
      send_flit("f1_body", 8'hA6, 1'b0, 2'b10, 16'h0D20, 3'b010, 2'b10, 3, 1'b0);
      chk("f1_busy_mid", 32'(busy), 32'd1);
      send_flit("f1_tail", 8'h0F, 1'b1, 2'b10, 16'h300C, 3'b100, 2'b10, 3, 1'b0);
      chk("f1_cnt3", 32'(flit_cnt), 32'd3);
      chk("f1_busy_end", 32'(busy), 32'd0);

      // Frame 2: s_last on head is ignored
      send_flit("f2_head", 8'h55, 1'b1, 2'b01, 16'h00F0, 3'b001, 2'b01, 1, 1'b0);
      chk("f2_in_frame", 32'(busy), 32'd1);
      send_flit("f2_tail", 8'hAA, 1'b1, 2'b01, 16'h0F00, 3'b100, 2'b01, 1, 1'b0);
      chk("f2_busy_end", 32'(busy), 32'd0);

      // Frame 3: s_vc changes mid-frame, held VC wins
      send_flit("f3_head", 8'hE4, 1'b0, 2'b10, 16'h8421, 3'b001, 2'b10, 1, 1'b0);
      send_flit("f3_tail", 8'h1B, 1'b1, 2'b01, 16'h1248, 3'b100, 2'b10, 1, 1'b0);

      // Frame 4: non-one-hot s_vc uses lowest bit
      send_flit("f4_head", 8'h00, 1'b0, 2'b11, 16'h000F, 3'b001, 2'b01, 1, 1'b0);
      send_flit("f4_tail", 8'hFF, 1'b1, 2'b11, 16'hF000, 3'b100, 2'b01, 1, 1'b0);

      // Frame 5: empty s_vc falls back to VC0
      send_flit("f5_head", 8'h35, 1'b0, 2'b00, 16'h4038, 3'b001, 2'b01, 1, 1'b0);
      send_flit("f5_tail", 8'h0F, 1'b1, 2'b00, 16'h300C, 3'b100, 2'b01, 1, 1'b0);

      // Frame 6: ack delayed 20 cycles with another beat pending
      send_flit("f6_head", 8'hA6, 1'b0, 2'b10, 16'h0D20, 3'b001, 2'b10, 20, 1'b1);
      send_flit("f6_tail", 8'h55, 1'b1, 2'b10, 16'h00F0, 3'b100, 2'b10, 20, 1'b1);
      chk("f6_cnt13", 32'(flit_cnt), 32'd13);

      // Frame 7: counter wraps 15 -> 0
      send_flit("f7_head", 8'h00, 1'b0, 2'b01, 16'h000F, 3'b001, 2'b01, 1, 1'b0);
      send_flit("f7_body0", 8'hFF, 1'b0, 2'b10, 16'hF000, 3'b010, 2'b01, 1, 1'b0);
      chk("wrap_15", 32'(flit_cnt), 32'd15);
      send_flit("f7_body1", 8'hAA, 1'b0, 2'b10, 16'h0F00, 3'b010, 2'b01, 1, 1'b0);
      chk("wrap_0", 32'(flit_cnt), 32'd0);
      send_flit("f7_tail", 8'h55, 1'b1, 2'b10, 16'h00F0, 3'b100, 2'b01, 1, 1'b0);

      // Reset pulsed while a head is in SEND
      n = 0;
      while (s_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      s_valid = 1'b1; s_data = 8'hE4; s_last = 1'b0; s_vc = 2'b10;
      @(posedge clk); #1;
      s_valid = 1'b0;
      doa = 1'b1;
      @(posedge clk); #1;
      chk("mid_send_dot", 32'(dot), 32'b001);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rails", 32'({do3, do2, do1, do0, dot, dovc}), 32'd0);
      chk("mid_rst_ready", 32'(s_ready), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_cnt", 32'(flit_cnt), 32'd0);
      exp_cnt = '0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      quiet = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         if (s_ready !== 1'b0) quiet = 1'b0;
      end
      chk("stuck_ack_ready", 32'(quiet), 32'd1);
      doa = 1'b0;
      n = 0;
      while (s_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("release_latency", 32'(n), 32'(SYNC));
      send_flit("r_head", 8'h1B, 1'b0, 2'b01, 16'h1248, 3'b001, 2'b01, 1, 1'b0);
      send_flit("r_tail", 8'h00, 1'b1, 2'b10, 16'h000F, 3'b100, 2'b01, 1, 1'b0);
      chk("r_busy_end", 32'(busy), 32'd0);
      chk("r_cnt2", 32'(flit_cnt), 32'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
